lift_car_controller: RTL and testbench
======================================

# lift_car_controller

Per-car controller at the dispatcher-facing end of the lift interface. It consumes hall assignments from the central dispatcher and in-car button presses, and runs a SCAN up/down service policy. It drives the car's motor and door, and reports car position and direction back to the dispatcher. One instance per car; all eleven floors (0–10) are served.

## Interface
- NUM_FLOORS, 11, floors served, encoded 0..NUM_FLOORS-1
- TRAVEL_CYCLES, 8, clock cycles to move one floor (≥2)
- DOOR_CYCLES, 16, clock cycles the door stays open per stop (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_in_lift  in  11  in-car buttons; bit i = floor i; sampled every cycle
- floor_req  in  4  dispatcher hall assignment; 0..10 = floor, 4'hF = none, 11..14 ignored
- lift_state  out  4  current floor
- lift_dir  out  2  00 idle, 01 up, 10 down
- motor_signal  out  2  00 stop, 01 up, 10 down
- door_open  out  1  door open
- arrive  out  1  one-cycle pulse on entering DOOR_OPEN
- pending  out  11  latched outstanding stops

## Operation
- **Pending latch:** every cycle, `pending |= req_in_lift | onehot(floor_req)` when floor_req ≤ 10.
  - A bit is cleared only when the car enters DOOR_OPEN at that floor.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- **Door-phase suppression:** while in DOOR_OPEN, a button or assignment for the current floor is not latched. A button press for the current floor restarts the door timer; an assignment for it does not.
- **last_dir:** register, reset to up, updated on every move.
- **States:**
  - IDLE: lift_dir=00, motor=00, door=0.
    - If pending[cur] → DOOR_OPEN.
    - Else if requests exist both above and below → move in last_dir.
    - Else if only above → MOVE_UP; if only below → MOVE_DOWN.
    - Else stay in IDLE.
  - MOVE_UP / MOVE_DOWN: motor=01/10, lift_dir=01/10. The travel counter counts TRAVEL_CYCLES cycles. On expiry, lift_state ±1 and nxt = new floor.
    - If pending[nxt] → DOOR_OPEN at that edge.
    - Else continue in the same direction; a request ahead must exist, since bits are never cleared in motion.
  - DOOR_OPEN: motor=00, door=1, lift_dir holds the last move direction. The door counter counts DOOR_CYCLES cycles, then the controller goes to IDLE.
- **Floor limits:** never increments past 10 or decrements below 0. A move is only started when a request exists strictly in that direction.
- **Reset mid-operation:** all state returns to reset values at once. Travel is abandoned and lift_state=0. This is a behavioural model with no physical re-homing.

## Timing
- **Reset values:** lift_state=0, lift_dir=00, motor_signal=00, door_open=0, arrive=0, pending=0, state=IDLE, counters=0, last_dir=up.
- **Button for the current floor while IDLE:**
  - Sampled in cycle N.
  - pending bit set at the end of N.
  - IDLE decides in N+1.
  - door_open=1 and arrive=1 in N+2; the bit is already clear in N+2.
- **Button for another floor while IDLE:** motor_signal is non-zero from N+2. lift_state changes at N+2+TRAVEL_CYCLES.
- **Stop at a floor:** the edge that updates lift_state also sets door_open=1 and motor=00 and pulses arrive. There is no stop-and-restart cycle when passing a floor.
- **Door phase:** door_open is high for exactly DOOR_CYCLES cycles unless restarted. IDLE then lasts ≥1 cycle before any motion.
- All outputs are registered.

## Test plan
Bench parameters: TRAVEL_CYCLES=4, DOOR_CYCLES=6.
- **Reset:** rst high 3 cycles → all outputs 0, pending=0. Assert rst mid-travel (floor 3, MOVE_UP) → next cycle lift_state=0, motor=00, pending=0.
- **Single trip:** cabin req floor 3 at cycle 0 → motor=01 from cycle 2; lift_state 1,2,3 at cycles 6,10,14. At cycle 14: arrive pulse, door_open=1, motor=00. door_open low at cycle 20; IDLE.
- **SCAN ordering:** at floor 5 going up, pending {7,2} → serves 7 then 2. lift_dir stays 01 until floor 7, then 10.
- **Tie break:** IDLE at 5, last_dir=down, requests at 8 and 1 simultaneously → moves down first.
- **Door phase:** in DOOR_OPEN at floor 4, cabin button 4 pressed at door-cycle 3 → door held a further 6 cycles; pending[4] stays 0. floor_req=4 during the door phase → not latched.
- **Invalid/idle assignments:** floor_req=4'hE or 4'hF with no cabin buttons for 50 cycles → pending=0, stays IDLE, motor=00.

Source files
------------

// File: rtl/lift_car_if.sv
// Dispatcher/car boundary: requests flow into the car, position and status flow back.
interface lift_car_if #(
  parameter int NUM_FLOORS = 11
);
  logic [NUM_FLOORS-1:0] req_in_lift;
  logic [3:0]            floor_req;
  logic [3:0]            lift_state;
  logic [1:0]            lift_dir;
  logic [1:0]            motor_signal;
  logic                  door_open;
  logic                  arrive;
  logic [NUM_FLOORS-1:0] pending;

  // Dispatcher / cabin-panel side
  modport master (
    output req_in_lift, floor_req,
    input  lift_state, lift_dir, motor_signal, door_open, arrive, pending
  );

  // Car controller side
  modport slave (
    input  req_in_lift, floor_req,
    output lift_state, lift_dir, motor_signal, door_open, arrive, pending
  );
endinterface

// File: rtl/lift_car_controller.sv
// Per-car SCAN controller: latches hall/cabin stops, drives motor and door,
// reports floor and direction back to the dispatcher.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | stopped, door closed, choosing next action from pending stops
// MOVE_UP   | travelling one floor up per TRAVEL_CYCLES
// MOVE_DOWN | travelling one floor down per TRAVEL_CYCLES
// DOOR_OPEN | stopped at a floor with the door open for DOOR_CYCLES
module lift_car_controller #(
  parameter int NUM_FLOORS    = 11,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  lift_car_if.slave  bus
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t                state;
  logic [3:0]            cur;
  logic [1:0]            dir_q;
  logic [1:0]            motor_q;
  logic                  door_q;
  logic                  arrive_q;
  logic [NUM_FLOORS-1:0] pend_q;
  logic [CW-1:0]         cnt;
  logic                  last_up;

  logic [NUM_FLOORS-1:0] hall, cur_oh, up_oh, dn_oh, set_vec;
  logic                  restart, at_top, at_bottom;
  logic                  any_above, any_below, ahead_up, ahead_dn;

  // Request decode, current-floor masking during the door phase, neighbour masks
  always_comb begin
    hall = '0;
    if (int'(bus.floor_req) < NUM_FLOORS) hall = ONE << bus.floor_req;
    cur_oh    = ONE << cur;
    up_oh     = ONE << (cur + 4'd1);
    dn_oh     = ONE << (cur - 4'd1);
    set_vec   = (bus.req_in_lift | hall) & ~((state == DOOR_OPEN) ? cur_oh : '0);
    restart   = (state == DOOR_OPEN) && (|(bus.req_in_lift & cur_oh));
    at_top    = (int'(cur) == NUM_FLOORS - 1);
    at_bottom = (cur == 4'd0);
  end

  // Where the outstanding stops lie relative to the car (and one floor beyond it)
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    ahead_up  = 1'b0;
    ahead_dn  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_q[i]) begin
        if (i > int'(cur))     any_above = 1'b1;
        if (i < int'(cur))     any_below = 1'b1;
        if (i > int'(cur) + 1) ahead_up  = 1'b1;
        if (i < int'(cur) - 1) ahead_dn  = 1'b1;
      end
    end
  end

  // Service FSM with registered outputs and pending latch; entering DOOR_OPEN clears that floor
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= 4'd0;
      dir_q    <= 2'b00;
      motor_q  <= 2'b00;
      door_q   <= 1'b0;
      arrive_q <= 1'b0;
      pend_q   <= '0;
      cnt      <= '0;
      last_up  <= 1'b1;
    end else begin
      arrive_q <= 1'b0;
      pend_q   <= pend_q | set_vec;
      case (state)
        IDLE: begin
          dir_q   <= 2'b00;
          motor_q <= 2'b00;
          door_q  <= 1'b0;
          if (|(pend_q & cur_oh)) begin
            state    <= DOOR_OPEN;
            door_q   <= 1'b1;
            arrive_q <= 1'b1;
            cnt      <= DOOR_LOAD;
            pend_q   <= (pend_q | set_vec) & ~cur_oh;
          end else if (any_above && (!any_below || last_up)) begin
            state   <= MOVE_UP;
            motor_q <= 2'b01;
            dir_q   <= 2'b01;
            last_up <= 1'b1;
            cnt     <= TRAVEL_LOAD;
          end else if (any_below) begin
            state   <= MOVE_DOWN;
            motor_q <= 2'b10;
            dir_q   <= 2'b10;
            last_up <= 1'b0;
            cnt     <= TRAVEL_LOAD;
          end
        end
        MOVE_UP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (at_top) begin
            state   <= IDLE;
            motor_q <= 2'b00;
            dir_q   <= 2'b00;
          end else begin
            cur     <= cur + 4'd1;
            last_up <= 1'b1;
            if (|(pend_q & up_oh)) begin
              state    <= DOOR_OPEN;
              motor_q  <= 2'b00;
              door_q   <= 1'b1;
              arrive_q <= 1'b1;
              cnt      <= DOOR_LOAD;
              pend_q   <= (pend_q | set_vec) & ~up_oh;
            end else if (ahead_up) begin
              cnt <= TRAVEL_LOAD;
            end else begin
              state   <= IDLE;
              motor_q <= 2'b00;
              dir_q   <= 2'b00;
            end
          end
        end
        MOVE_DOWN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (at_bottom) begin
            state   <= IDLE;
            motor_q <= 2'b00;
            dir_q   <= 2'b00;
          end else begin
            cur     <= cur - 4'd1;
            last_up <= 1'b0;
            if (|(pend_q & dn_oh)) begin
              state    <= DOOR_OPEN;
              motor_q  <= 2'b00;
              door_q   <= 1'b1;
              arrive_q <= 1'b1;
              cnt      <= DOOR_LOAD;
              pend_q   <= (pend_q | set_vec) & ~dn_oh;
            end else if (ahead_dn) begin
              cnt <= TRAVEL_LOAD;
            end else begin
              state   <= IDLE;
              motor_q <= 2'b00;
              dir_q   <= 2'b00;
            end
          end
        end
        DOOR_OPEN: begin
          if (restart) begin
            cnt <= DOOR_LOAD;
          end else if (cnt == '0) begin
            state  <= IDLE;
            door_q <= 1'b0;
            dir_q  <= 2'b00;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lift_state   = cur;
  assign bus.lift_dir     = dir_q;
  assign bus.motor_signal = motor_q;
  assign bus.door_open    = door_q;
  assign bus.arrive       = arrive_q;
  assign bus.pending      = pend_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// Bench for lift_car_controller: directed scenarios plus random traffic,
// every cycle compared against a floor/phase/timer reference model.
module tb_lift_car_controller;

  localparam int NF = 11;
  localparam int T  = 4;
  localparam int D  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  lift_car_if #(.NUM_FLOORS(NF)) bus ();

  lift_car_controller #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: mode 0 idle, 1 travelling, 2 door open; dir codes 0/1(up)/2(down)
  int         m_floor, m_mode, m_dir, m_last, m_timer;
  bit         m_arrive, m_from_idle;
  bit [NF-1:0] m_pend;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_floor = 0; m_mode = 0; m_dir = 0; m_last = 1; m_timer = 0;
    m_arrive = 0; m_from_idle = 0; m_pend = '0;
  endtask

  task automatic model_open(input bit from_idle, inout bit [NF-1:0] nxt);
    m_mode = 2; m_timer = D; m_arrive = 1; m_from_idle = from_idle;
    nxt[m_floor] = 1'b0;
  endtask

  task automatic model_step(input logic [NF-1:0] btn, input logic [3:0] fr);
    bit [NF-1:0] nxt;
    bit up, down;
    int go;
    nxt = m_pend;
    m_arrive = 0;
    for (int i = 0; i < NF; i++)
      if ((btn[i] || int'(fr) == i) && !(m_mode == 2 && i == m_floor)) nxt[i] = 1'b1;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) model_open(1'b1, nxt);
        else begin
          up = 0; down = 0;
          for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && i > m_floor) up = 1;
            if (m_pend[i] && i < m_floor) down = 1;
          end
          go = (up && down) ? m_last : up ? 1 : down ? 2 : 0;
          if (go != 0) begin
            m_mode = 1; m_dir = go; m_last = go; m_timer = T;
          end
        end
      end
      1: begin
        m_timer--;
        if (m_timer == 0) begin
          m_floor += (m_dir == 1) ? 1 : -1;
          if (m_pend[m_floor]) model_open(1'b0, nxt);
          else m_timer = T;
        end
      end
      default: begin
        if (btn[m_floor]) m_timer = D;
        else begin
          m_timer--;
          if (m_timer == 0) begin m_mode = 0; m_dir = 0; end
        end
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic compare_all();
    check("lift_state", int'(bus.lift_state), m_floor);
    check("motor_signal", int'(bus.motor_signal), (m_mode == 1) ? m_dir : 0);
    check("door_open", int'(bus.door_open), (m_mode == 2) ? 1 : 0);
    check("arrive", int'(bus.arrive), int'(m_arrive));
    check("pending", int'(bus.pending), int'(m_pend));
    if (!(m_mode == 2 && m_from_idle)) check("lift_dir", int'(bus.lift_dir), m_dir);
  endtask

  // one clock: drive inputs at the falling edge, advance model, sample at next falling edge
  task automatic tick(input logic [NF-1:0] btn, input logic [3:0] fr, input logic r);
    bus.req_in_lift = btn;
    bus.floor_req   = fr;
    rst             = r;
    if (r) model_reset();
    else   model_step(btn, fr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_tick();
    tick('0, 4'hF, 1'b0);
  endtask

  task automatic wait_arrive(input int fl, input string tag);
    int k;
    k = 0;
    while (!(bus.arrive && int'(bus.lift_state) == fl) && k < 300) begin
      idle_tick();
      k++;
    end
    check(tag, (bus.arrive && int'(bus.lift_state) == fl) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int cnt, k;
    bit saw;
    logic [NF-1:0] btn;
    logic [3:0]    fr;
    bus.req_in_lift = '0;
    bus.floor_req   = 4'hF;
    model_reset();
    @(negedge clk);

    // reset held three cycles
    for (int i = 0; i < 3; i++) tick('0, 4'hF, 1'b1);
    check("rst_lift_state", int'(bus.lift_state), 0);
    check("rst_motor", int'(bus.motor_signal), 0);
    check("rst_door", int'(bus.door_open), 0);
    check("rst_pending", int'(bus.pending), 0);
    idle_tick();

    // single trip to floor 3, button sampled in cycle 0
    tick(11'h008, 4'hF, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 1)  check("trip_motor_c1", int'(bus.motor_signal), 0);
      if (c == 2)  check("trip_motor_c2", int'(bus.motor_signal), 1);
      if (c == 5)  check("trip_floor_c5", int'(bus.lift_state), 0);
      if (c == 6)  check("trip_floor_c6", int'(bus.lift_state), 1);
      if (c == 10) check("trip_floor_c10", int'(bus.lift_state), 2);
      if (c == 13) check("trip_door_c13", int'(bus.door_open), 0);
      if (c == 14) begin
        check("trip_floor_c14", int'(bus.lift_state), 3);
        check("trip_arrive_c14", int'(bus.arrive), 1);
        check("trip_door_c14", int'(bus.door_open), 1);
        check("trip_motor_c14", int'(bus.motor_signal), 0);
      end
      if (c == 15) check("trip_arrive_c15", int'(bus.arrive), 0);
      if (c == 19) check("trip_door_c19", int'(bus.door_open), 1);
      if (c == 20) begin
        check("trip_door_c20", int'(bus.door_open), 0);
        check("trip_dir_c20", int'(bus.lift_dir), 0);
      end
      if (c < 20) idle_tick();
    end

    // reset while moving up out of floor 3
    tick(11'h200, 4'hF, 1'b0);
    idle_tick();
    idle_tick();
    check("midrst_pre_motor", int'(bus.motor_signal), 1);
    tick('0, 4'hF, 1'b1);
    check("midrst_floor", int'(bus.lift_state), 0);
    check("midrst_motor", int'(bus.motor_signal), 0);
    check("midrst_pending", int'(bus.pending), 0);
    idle_tick();

    // SCAN: stop at 5 going up, then 7 and 2 pending -> 7 first
    tick(11'h0A0, 4'hF, 1'b0);
    wait_arrive(5, "scan_arrive5");
    tick(11'h004, 4'hF, 1'b0);
    saw = 0; k = 0;
    while (!(bus.arrive && bus.lift_state == 4'd7) && k < 300) begin
      if (bus.lift_dir == 2'b10) saw = 1;
      idle_tick(); k++;
    end
    check("scan_arrive7", int'(bus.lift_state), 7);
    check("scan_no_down_before7", int'(saw), 0);
    check("scan_pend2_kept", int'(bus.pending[2]), 1);
    saw = 0; k = 0;
    while (!(bus.arrive && bus.lift_state == 4'd2) && k < 300) begin
      if (bus.motor_signal == 2'b01) saw = 1;
      idle_tick(); k++;
    end
    check("scan_arrive2", int'(bus.lift_state), 2);
    check("scan_no_up_after7", int'(saw), 0);
    check("scan_dir_at2", int'(bus.lift_dir), 2);

    // tie break: idle at 5 after moving down, 8 and 1 together -> down first
    tick(11'h040, 4'hF, 1'b0);
    wait_arrive(6, "tie_arrive6");
    tick(11'h020, 4'hF, 1'b0);
    wait_arrive(5, "tie_arrive5");
    k = 0;
    while (bus.door_open && k < 50) begin idle_tick(); k++; end
    idle_tick();
    tick(11'h102, 4'hF, 1'b0);
    idle_tick();
    check("tie_motor", int'(bus.motor_signal), 2);
    check("tie_dir", int'(bus.lift_dir), 2);
    wait_arrive(1, "tie_arrive1");
    wait_arrive(8, "tie_arrive8");

    // door phase at floor 4: assignment for 4 neither latches nor restarts
    tick(11'h010, 4'hF, 1'b0);
    wait_arrive(4, "door_arrive4a");
    cnt = 1; k = 0;
    while (bus.door_open && k < 50) begin
      tick('0, 4'h4, 1'b0);
      if (bus.door_open) cnt++;
      k++;
    end
    check("door_len_assign", cnt, D);
    check("door_assign_not_latched", int'(bus.pending), 0);
    idle_tick();
    // cabin button 4 at door-cycle 3 holds the door six more cycles
    tick(11'h010, 4'hF, 1'b0);
    wait_arrive(4, "door_arrive4b");
    idle_tick(); idle_tick(); idle_tick();
    tick(11'h010, 4'hF, 1'b0);
    check("door_btn_not_latched", int'(bus.pending[4]), 0);
    cnt = 0; k = 0;
    while (bus.door_open && k < 50) begin
      cnt++;
      idle_tick(); k++;
    end
    check("door_len_restart", cnt, D);
    check("door_after_pending", int'(bus.pending), 0);

    // invalid / none assignments for 50 cycles
    for (int i = 0; i < 50; i++) tick('0, (i % 2) ? 4'hE : 4'hF, 1'b0);
    check("inv_pending", int'(bus.pending), 0);
    check("inv_motor", int'(bus.motor_signal), 0);
    check("inv_door", int'(bus.door_open), 0);
    check("inv_floor", int'(bus.lift_state), 4);

    // random traffic with occasional reset
    for (int i = 0; i < 2500; i++) begin
      btn = '0;
      if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, NF - 1)] = 1'b1;
      fr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      tick(btn, fr, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
